// File: rtl/dm_io.sv
// dm_io: 256x32 data RAM, LED register and an optional down-counting timer on a CPU data bus.
// Latency: loads are combinational from addr; stores commit at the next posedge of clk.
// Backpressure: none, so every access completes in one cycle. DM_TIMER_EN enables the timer block.
module dm_io (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [15:0] led,
  output logic        irq
);

  // ---------------------------------------------------------------------------
  // Address decode (addr[1:0] ignored everywhere)
  // ---------------------------------------------------------------------------
  logic in_ram;
  logic in_io;
  logic sel_led;

  assign in_ram  = (addr[31:10] == 22'd0);
  assign in_io   = (addr[31:16] == 16'd0) && (addr[15:4] == 12'h7F0);
  assign sel_led = in_io && (addr[3:2] == 2'd0);

  // ---------------------------------------------------------------------------
  // Data RAM: not reset, write-first is not used so same-cycle reads see old data
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [0:255];

  // Store into RAM on the strobe edge
  always_ff @(posedge clk) begin
    if (MemWrite && in_ram) begin
      ram_q[addr[9:2]] <= din;
    end
  end

  // ---------------------------------------------------------------------------
  // LED register
  // ---------------------------------------------------------------------------
  logic [15:0] led_d;
  logic [15:0] led_q;

  // Next LED value: low half of the store data when addressed
  always_comb begin
    led_d = led_q;
    if (MemWrite && sel_led) begin
      led_d = din[15:0];
    end
  end

  // LED state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= 16'd0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

`ifdef DM_TIMER_EN
  // ---------------------------------------------------------------------------
  // Timer: CTRL {IE, MODE, EN}, PRESET, COUNT and a four-state FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_LOAD  = 2'd1,
    T_COUNT = 2'd2,
    T_DONE  = 2'd3
  } tstate_t;

  logic sel_ctrl;
  logic sel_preset;
  logic sel_count;

  assign sel_ctrl   = in_io && (addr[3:2] == 2'd1);
  assign sel_preset = in_io && (addr[3:2] == 2'd2);
  assign sel_count  = in_io && (addr[3:2] == 2'd3);

  tstate_t     state_d, state_q;
  logic [2:0]  ctrl_d, ctrl_q;
  logic [31:0] preset_d, preset_q;
  logic [31:0] count_d, count_q;
  logic        irq_d, irq_q;

  // Timer next-state: FSM step first, then a CTRL store overrides it
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;

    if (MemWrite && sel_preset) begin
      preset_d = din;
    end

    case (state_q)
      T_IDLE: begin
        state_d = T_IDLE;
      end
      T_LOAD: begin
        count_d = preset_q;
        state_d = (preset_q == 32'd0) ? T_DONE : T_COUNT;
      end
      T_COUNT: begin
        // The <=1 guard also covers a zero count, so the counter never wraps
        if (count_q <= 32'd1) begin
          count_d = 32'd0;
          state_d = T_DONE;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      T_DONE: begin
        // Auto-reload reloads exactly like LOAD; a zero preset stays in DONE
        if (ctrl_q[1]) begin
          count_d = preset_q;
          state_d = (preset_q == 32'd0) ? T_DONE : T_COUNT;
        end
      end
      default: begin
        state_d = T_IDLE;
      end
    endcase

    if (MemWrite && sel_ctrl) begin
      ctrl_d  = din[2:0];
      count_d = count_q;
      state_d = din[0] ? T_LOAD : T_IDLE;
    end

    // irq is registered off the next state so it tracks DONE && IE exactly
    irq_d = (state_d == T_DONE) && ctrl_d[2];
  end

  // Timer state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= T_IDLE;
      ctrl_q   <= 3'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

  // Load data mux with timer registers
  always_comb begin
    dout = 32'd0;
    if (in_ram) begin
      dout = ram_q[addr[9:2]];
    end else if (sel_led) begin
      dout = {16'd0, led_q};
    end else if (sel_ctrl) begin
      dout = {28'd0, (state_q == T_DONE), ctrl_q};
    end else if (sel_preset) begin
      dout = preset_q;
    end else if (sel_count) begin
      dout = count_q;
    end
  end
`else
  assign irq = 1'b0;

  // Load data mux without the timer: its register window reads 0
  always_comb begin
    dout = 32'd0;
    if (in_ram) begin
      dout = ram_q[addr[9:2]];
    end else if (sel_led) begin
      dout = {16'd0, led_q};
    end
  end
`endif

endmodule

// File: tb/tb_dm_io.sv
// Directed self-checking bench for dm_io; covers the timer only when DM_TIMER_EN is defined.
module tb_dm_io;

  logic        clk;
  logic        rst;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [15:0] led;
  logic        irq;

  int n_chk;
  int n_pass;

  dm_io dut (
    .clk      (clk),
    .rst      (rst),
    .MemWrite (MemWrite),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .led      (led),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Store one word; returns 1ns after the committing edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1;
    addr     = a;
    din      = d;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  // Combinational load check
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst      = 1'b1;
    MemWrite = 1'b0;
    addr     = 32'd0;
    din      = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_led", {16'd0, led}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_led_rd", 32'h0000_7F00, 32'd0);
    rd_chk("rst_ctrl_rd", 32'h0000_7F04, 32'd0);

    // RAM write and byte-offset reads
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_rd_13", 32'h0000_0013, 32'hDEAD_BEEF);
    rd_chk("ram_rd_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_oob_400", 32'h0000_0400, 32'd0);
    wr(32'h0000_03FC, 32'h0BAD_F00D);
    rd_chk("ram_top", 32'h0000_03FC, 32'h0BAD_F00D);

    // Read of the word being written returns old data until the edge
    wr(32'h0000_0014, 32'h1111_1111);
    MemWrite = 1'b1;
    addr     = 32'h0000_0014;
    din      = 32'h2222_2222;
    #1;
    check("raw_old", dout, 32'h1111_1111);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    check("raw_new", dout, 32'h2222_2222);

    // LED register
    wr(32'h0000_7F00, 32'h0001_A5A5);
    check("led_out", {16'd0, led}, 32'h0000_A5A5);
    rd_chk("led_rd", 32'h0000_7F00, 32'h0000_A5A5);
    // Upper address bits set: unmapped, write ignored, read 0
    wr(32'h0001_7F00, 32'h0000_1234);
    check("led_unmapped_wr", {16'd0, led}, 32'h0000_A5A5);
    rd_chk("unmapped_rd", 32'h1000_7F00, 32'd0);
    rd_chk("unmapped_io_rd", 32'h0000_7F10, 32'd0);
    // Unmapped write must not alias into RAM
    wr(32'h0001_0010, 32'h5555_5555);
    rd_chk("ram_no_alias", 32'h0000_0010, 32'hDEAD_BEEF);

`ifdef DM_TIMER_EN
    // COUNT is read-only
    wr(32'h0000_7F0C, 32'h0000_0077);
    rd_chk("count_ro", 32'h0000_7F0C, 32'd0);

    // One-shot, PRESET=5: DONE/irq after edge N+6, COUNT steps 5..0
    wr(32'h0000_7F08, 32'd5);
    rd_chk("preset_rd", 32'h0000_7F08, 32'd5);
    wr(32'h0000_7F04, 32'h5);
    check("os_irq_n", {31'd0, irq}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("os_irq_%0d", k), {31'd0, irq}, (k == 6) ? 32'd1 : 32'd0);
      rd_chk($sformatf("os_cnt_%0d", k), 32'h0000_7F0C, 32'(6 - k));
    end
    rd_chk("os_ctrl_done", 32'h0000_7F04, 32'hD);
    repeat (3) @(posedge clk);
    #1;
    check("os_irq_hold", {31'd0, irq}, 32'd1);
    wr(32'h0000_7F04, 32'h0);
    check("os_irq_clr", {31'd0, irq}, 32'd0);
    rd_chk("os_ctrl_clr", 32'h0000_7F04, 32'h0);

    // Auto-reload, PRESET=3: one-cycle pulse every 4 cycles
    wr(32'h0000_7F08, 32'd3);
    wr(32'h0000_7F04, 32'h7);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("ar_irq_%0d", k), {31'd0, irq}, (k % 4 == 0) ? 32'd1 : 32'd0);
      rd_chk($sformatf("ar_ctrl_%0d", k), 32'h0000_7F04, (k % 4 == 0) ? 32'hF : 32'h7);
    end
    wr(32'h0000_7F04, 32'h0);
    check("ar_irq_off", {31'd0, irq}, 32'd0);

    // IE=0: DONE reached but irq stays low
    wr(32'h0000_7F08, 32'd2);
    wr(32'h0000_7F04, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("noie_irq", {31'd0, irq}, 32'd0);
    rd_chk("noie_ctrl", 32'h0000_7F04, 32'h9);
    wr(32'h0000_7F04, 32'h0);

    // PRESET=0 written at edge M, CTRL at M+1: irq after edge M+2
    wr(32'h0000_7F08, 32'd0);
    wr(32'h0000_7F04, 32'h5);
    check("p0_irq_m1", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    check("p0_irq_m2", {31'd0, irq}, 32'd1);
    rd_chk("p0_cnt", 32'h0000_7F0C, 32'd0);
    wr(32'h0000_7F04, 32'h0);

    // Reset mid-count, PRESET=100
    wr(32'h0000_7F08, 32'd100);
    wr(32'h0000_7F04, 32'h5);
    repeat (10) @(posedge clk);
    #1;
    wr(32'h0000_7F00, 32'h0000_1234);
    rd_chk("mid_cnt", 32'h0000_7F0C, 32'd90);
    rst = 1'b1;
    #1;
    check("mr_irq", {31'd0, irq}, 32'd0);
    check("mr_led", {16'd0, led}, 32'd0);
    rd_chk("mr_cnt", 32'h0000_7F0C, 32'd0);
    rd_chk("mr_ctrl", 32'h0000_7F04, 32'd0);
    rd_chk("mr_preset", 32'h0000_7F08, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`else
    // Timer absent: window reads 0, writes ignored, irq stays 0
    wr(32'h0000_7F08, 32'd2);
    wr(32'h0000_7F04, 32'h5);
    repeat (6) @(posedge clk);
    #1;
    check("nt_irq", {31'd0, irq}, 32'd0);
    rd_chk("nt_ctrl", 32'h0000_7F04, 32'd0);
    rd_chk("nt_preset", 32'h0000_7F08, 32'd0);
    rd_chk("nt_count", 32'h0000_7F0C, 32'd0);
    rst = 1'b1;
    #1;
    check("mr_led", {16'd0, led}, 32'd0);
    check("mr_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    // RAM survives reset
    rd_chk("ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_keep2", 32'h0000_0014, 32'h2222_2222);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dm_io.md
DM_IO -- requirements
Module: dm_io

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port MemWrite, input, 1, CPU store strobe; a write commits at the next posedge.
REQ-004 SHALL have port addr, input, 32, byte address (CPU aluout); addr[1:0] ignored.
REQ-005 SHALL have port din, input, 32, store data (CPU writedata).
REQ-006 SHALL have port dout, output, 32, load data (CPU readdata); combinational.
REQ-007 SHALL have port led, output, 16, LED register contents.
REQ-008 SHALL have port irq, output, 1, timer interrupt, registered.
REQ-009 SHALL use one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-010 SHALL map 0x0000_0000-0x0000_03FF to 256x32 RAM indexed by addr[9:2].
REQ-011 SHALL map 0x7F00 LED (R/W, bits[15:0]), 0x7F04 CTRL (R/W), 0x7F08 PRESET (R/W, 32b), 0x7F0C COUNT (read-only); upper addr bits [31:16] must be 0.
REQ-012 SHALL return 0 on reads of unmapped addresses and ignore writes to them and to COUNT.
REQ-013 SHALL read RAM and registers combinationally; a read of the address being written returns old data until the edge.
REQ-014 CTRL bits: [0] EN, [1] MODE (0 one-shot, 1 auto-reload), [2] IE, [3] DONE (read-only, state==DONE); bits [31:4] read 0.
REQ-015 Timer FSM states IDLE, LOAD, COUNT, DONE; reset state IDLE.
REQ-016 CTRL write with EN=1 -> LOAD at that edge; CTRL write with EN=0 -> IDLE from any state, COUNT holds.
REQ-017 LOAD: next edge COUNT<=PRESET and go COUNT; if PRESET==0, COUNT<=0 and go DONE.
REQ-018 COUNT: decrement by 1 per edge; on edge where COUNT==1, COUNT<=0 and go DONE.
REQ-019 Latency: CTRL write EN=1 at edge N with PRESET=P>0 -> DONE and irq (if IE) visible after edge N+P+1.
REQ-020 DONE, MODE=0: hold DONE; irq = IE, level, until CTRL written.
REQ-021 DONE, MODE=1: stay one cycle, irq high that cycle if IE, next edge COUNT<=PRESET and go COUNT (period P+1 cycles).
REQ-022 CTRL write takes priority over any same-cycle FSM transition; PRESET write during COUNT affects only the next load.
REQ-023 irq SHALL be registered: high exactly while state==DONE and IE==1.

Reset
REQ-024 rst SHALL force immediately: led=0, irq=0, CTRL=0, PRESET=0, COUNT=0, state IDLE, including mid-count.
REQ-025 RAM contents SHALL NOT be reset; dout after reset reflects addr decode of reset registers.

Configuration
REQ-026 Macro DM_TIMER_EN defined: timer (CTRL, PRESET, COUNT, FSM, irq) present as above.
REQ-027 DM_TIMER_EN undefined: timer logic absent; 0x7F04-0x7F0C read 0, writes ignored, irq tied 0; RAM and LED unchanged.

Verification
REQ-028 Write 0xDEADBEEF to 0x0000_0010, read 0x0000_0013 -> dout=0xDEADBEEF; read 0x0000_0400 -> 0.
REQ-029 Write 0x0001A5A5 to 0x7F00 -> led=0xA5A5; read 0x7F00 -> 0x0000A5A5.
REQ-030 PRESET=5, CTRL=0x5 (EN, one-shot, IE) at edge N -> irq rises after edge N+6, COUNT=0, stays high; CTRL=0 -> irq low after next edge.
REQ-031 PRESET=3, CTRL=0x7 (auto-reload) -> irq one-cycle pulses every 4 cycles; CTRL read bit3 toggles accordingly.
REQ-032 PRESET=0, CTRL=0x5 -> irq high after edge N+2; assert rst mid-count with PRESET=100 -> irq, COUNT, led, CTRL read 0 immediately.
